neg_serial_unit: RTL and testbench

- Parametrised multi-cycle two's-complement negate/absolute-value unit for the ALU datapath.
- Successor to the single-cycle 32-bit combinational negate. Generalised in width, processes DIGIT bits per clock with ripple carry between digits, and adds modes, a start/done handshake and an overflow flag.
- Sits beside the ALU. The control unit pulses start, waits for done, then latches Rz into the Z register.

---
 rtl/neg_serial_unit.sv | 137 +++++++++++++
 tb/tb_neg_serial_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/neg_serial_unit.sv
// neg_serial_unit: digit-serial two's-complement NEG/ABS/PASS/NOT unit with a start/done handshake.
// Defining NEG_SERIAL_ZERO_FLAG_EN adds the zf (result == 0) output.
module neg_serial_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] Ra,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Rz,
  output logic             ovf
`ifdef NEG_SERIAL_ZERO_FLAG_EN
  ,
  output logic             zf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]    LAST     = CW'(N - 1);
  localparam logic [1:0]       MODE_NEG = 2'b00;
  localparam logic [1:0]       MODE_ABS = 2'b01;
  localparam logic [1:0]       MODE_NOT = 2'b11;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] opnd_r;
  logic             inv_r, carry_r, ovf_pend_r;
  logic [CW-1:0]    cnt_r;
  logic [DIGIT-1:0] digit_s;
  logic [DIGIT:0]   sum_s;
  logic [WIDTH-1:0] rz_nxt_s;
  logic             last_s;
  logic             inv_start_s, carry_start_s, ovf_start_s;

  // Per-request flags derived from the operand and mode presented with start.
  always_comb begin
    inv_start_s   = (mode == MODE_NEG) | (mode == MODE_NOT) | ((mode == MODE_ABS) & Ra[WIDTH-1]);
    carry_start_s = (mode == MODE_NEG) | ((mode == MODE_ABS) & Ra[WIDTH-1]);
    ovf_start_s   = ((mode == MODE_NEG) | (mode == MODE_ABS)) & (Ra == MOST_NEG);
  end

  // One digit of the ripple: conditional invert plus incoming carry.
  always_comb begin
    digit_s  = inv_r ? ~opnd_r[DIGIT-1:0] : opnd_r[DIGIT-1:0];
    sum_s    = {1'b0, digit_s} + {{DIGIT{1'b0}}, carry_r};
    rz_nxt_s = {sum_s[DIGIT-1:0], Rz[WIDTH-1:DIGIT]};
    last_s   = (cnt_r == LAST);
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = DONE;
        else        state_nxt_s = RUN;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      Rz         <= {WIDTH{1'b0}};
      ovf        <= 1'b0;
      opnd_r     <= {WIDTH{1'b0}};
      inv_r      <= 1'b0;
      carry_r    <= 1'b0;
      ovf_pend_r <= 1'b0;
      cnt_r      <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
      done    <= (state_nxt_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            opnd_r     <= Ra;
            inv_r      <= inv_start_s;
            carry_r    <= carry_start_s;
            ovf_pend_r <= ovf_start_s;
            cnt_r      <= {CW{1'b0}};
            ovf        <= 1'b0;
          end
        end
        RUN: begin
          Rz      <= rz_nxt_s;
          opnd_r  <= opnd_r >> DIGIT;
          carry_r <= sum_s[DIGIT];
          cnt_r   <= cnt_r + CW'(1);
          // The carry out of the top digit is simply dropped on the last step.
          if (last_s) ovf <= ovf_pend_r;
        end
        DONE:    ;
        default: ;
      endcase
    end
  end

`ifdef NEG_SERIAL_ZERO_FLAG_EN
  // Zero flag captured on the same edge the final digit lands in Rz.
  always_ff @(posedge clock) begin
    if (clear) begin
      zf <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      zf <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      zf <= (rz_nxt_s == {WIDTH{1'b0}});
    end else begin
      zf <= zf;
    end
  end
`else
  // Zero detection is not built in this configuration.
`endif

endmodule

// File: tb/tb_neg_serial_unit.sv
// Directed self-checking bench for neg_serial_unit (WIDTH=32, DIGIT=4).
module tb_neg_serial_unit;

  localparam logic [1:0] M_NEG  = 2'b00;
  localparam logic [1:0] M_ABS  = 2'b01;
  localparam logic [1:0] M_PASS = 2'b10;
  localparam logic [1:0] M_NOT  = 2'b11;

  logic        clock;
  logic        clear;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] Ra;
  logic        busy;
  logic        done;
  logic [31:0] Rz;
  logic        ovf;
`ifdef NEG_SERIAL_ZERO_FLAG_EN
  logic        zf;
`endif

  int checks = 0;
  int errors = 0;

  neg_serial_unit #(.WIDTH(32), .DIGIT(4)) dut (
    .clock (clock),
    .clear (clear),
    .start (start),
    .mode  (mode),
    .Ra    (Ra),
    .busy  (busy),
    .done  (done),
    .Rz    (Rz),
    .ovf   (ovf)
`ifdef NEG_SERIAL_ZERO_FLAG_EN
    ,
    .zf    (zf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge: start is sampled at the next rising edge (edge 0).
  task automatic op(input string tag, input logic [31:0] ra, input logic [1:0] md,
                    input logic [31:0] exp_rz, input logic exp_ovf, input logic exp_zf);
    int k;
    start = 1'b1;
    Ra    = ra;
    mode  = md;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    k = 0;
    while (!done && k < 20) begin
      @(negedge clock);
      k++;
    end
    check({tag, "_latency"}, k, 32'd8);
    check({tag, "_rz"}, Rz, exp_rz);
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`ifdef NEG_SERIAL_ZERO_FLAG_EN
    check({tag, "_zf"}, {31'd0, zf}, {31'd0, exp_zf});
`else
    if (exp_zf) k = 0;
`endif
    @(negedge clock);
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    int first;
    clear = 1'b1;
    start = 1'b0;
    mode  = M_NEG;
    Ra    = 32'd0;
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rz", Rz, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    clear = 1'b0;
    @(negedge clock);

    op("neg_zero", 32'h0000_0000, M_NEG, 32'h0000_0000, 1'b0, 1'b1);
    op("neg_maxpos", 32'h7FFF_FFFF, M_NEG, 32'h8000_0001, 1'b0, 1'b0);
    op("neg_minus1", 32'hFFFF_FFFF, M_NEG, 32'h0000_0001, 1'b0, 1'b0);
    op("neg_min", 32'h8000_0000, M_NEG, 32'h8000_0000, 1'b1, 1'b0);
    op("abs_min", 32'h8000_0000, M_ABS, 32'h8000_0000, 1'b1, 1'b0);
    op("pass_5", 32'h0000_0005, M_PASS, 32'h0000_0005, 1'b0, 1'b0);
    op("abs_neg10", 32'hFFFF_FFF6, M_ABS, 32'h0000_000A, 1'b0, 1'b0);
    op("abs_pos10", 32'h0000_000A, M_ABS, 32'h0000_000A, 1'b0, 1'b0);
    op("not_0f", 32'h0F0F_0F0F, M_NOT, 32'hF0F0_F0F0, 1'b0, 1'b0);

    // Second start at edge 3 with a new operand must be ignored.
    start = 1'b1;
    Ra    = 32'h1234_5678;
    mode  = M_NEG;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    Ra    = 32'h0000_0000;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ign_busy", {31'd0, busy}, 32'd1);
    pulses = 0;
    first  = -1;
    for (int k = 4; k <= 20; k++) begin
      @(negedge clock);
      if (done) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    check("ign_pulses", pulses, 32'd1);
    check("ign_latency", first, 32'd8);
    check("ign_rz", Rz, 32'hEDCB_A988);
    check("ign_ovf", {31'd0, ovf}, 32'd0);

    // Clear sampled at edge 4 aborts the operation.
    start = 1'b1;
    Ra    = 32'h1234_5678;
    mode  = M_NEG;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_rz", Rz, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done) pulses++;
    end
    check("clr_no_done", pulses, 32'd0);
    op("neg_one", 32'h0000_0001, M_NEG, 32'hFFFF_FFFF, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
